mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Arbitrates the single unified instruction/data memory (`mem`: combinational read, synchronous write, word-addressed via a[31:2]) between the fetch unit and the load/store unit of the multicycle core.
Uses a req/ack handshake per requester, with data-first priority and a starvation limit for fetch.
Drives mem's we/a/wd, captures rd into registered response data, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
MEM_WORDS, 64, number of 32-bit words in mem; word index must be < MEM_WORDS.
MAX_DSTREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win (range 1..15).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
i_req  in  1  fetch request; held high until i_ack.
i_addr  in  32  fetch byte address; stable while i_req is high.
i_ack  out  1  one-cycle fetch completion pulse.
i_rdata  out  32  fetched word, valid while i_ack=1.
i_err  out  1  fetch error, valid with i_ack.
d_req  in  1  data request; held high until d_ack.
d_we  in  1  1 = store, 0 = load; stable with d_req.
d_addr  in  32  data byte address; stable with d_req.
d_wdata  in  32  store data; stable with d_req.
d_ack  out  1  one-cycle data completion pulse.
d_rdata  out  32  load word, valid while d_ack=1; 0 for stores.
d_err  out  1  data error, valid with d_ack.
mem_we  out  1  to mem.we.
mem_a  out  32  to mem.a.
mem_wd  out  32  to mem.wd.
mem_rd  in  32  from mem.rd.

Behaviour:
- Clock and reset: one clock (clk). reset_n is asynchronous and active-low.
- Reset value of every output is 0: i_ack, i_err, i_rdata, d_ack, d_err, d_rdata, mem_we, mem_a, mem_wd. Internal state after reset: state=IDLE, owner=NONE, dstreak=0.
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE: if no request, stay in IDLE. Otherwise latch the winner into owner and go to ACCESS.
  - Only one request pending: that requester wins.
  - Both pending: D wins unless dstreak==MAX_DSTREAK, in which case I wins.
- ACCESS:
  - Drive mem_a from the owner's address.
  - Drive mem_we = d_we only if owner=D and the address is legal; otherwise mem_we=0.
  - Drive mem_wd = d_wdata if owner=D, else 0.
  - On the closing edge, register mem_rd into the owner's rdata (0 for stores and for errors), register the err bit, and go to RESP.
- Legal address: addr[1:0]==0 and addr[31:2] < MEM_WORDS. An illegal access never writes memory and returns rdata=0, err=1.
- RESP: pulse the owner's ack for exactly one cycle, with rdata/err held valid. Then go to IDLE, clear rdata/err, and set owner=NONE.
- In IDLE and RESP, mem_we=0, mem_a=0, mem_wd=0.
- Latency: request seen high in IDLE at cycle 0 → ACCESS at cycle 1 → ack at cycle 2. Throughput is one access per 3 cycles. A requester holding req high after its ack is re-arbitrated from IDLE.
- dstreak update:
  - D granted while i_req=1: dstreak+1, saturating at MAX_DSTREAK.
  - I granted: dstreak=0.
  - D granted while i_req=0: dstreak=0.
- i_ack and d_ack are never high in the same cycle.
- Protocol violation (req dropped before ack): the access still completes with the current inputs and ack still pulses. Behaviour is defined, but the bench does not rely on it.
- Reset asserted mid-operation: outputs go to 0 immediately (mem_we is combinational from state, so a pending ACCESS write is suppressed). State returns to IDLE with no ack.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - owner enum {NONE, OWN_I, OWN_D}.
  - constant WORD_SHIFT=2.
- Sub-module mem_arb_pick: combinational winner select from i_req, d_req, dstreak and MAX_DSTREAK, plus the next-dstreak value. The FSM, mux and response registers stay in mem_arbiter.

Test Plan:
- Single store then load: d_req with d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF → d_ack at cycle 2 with d_err=0. Then d_we=0, d_addr=0x10 → d_rdata=0xDEADBEEF with d_ack; i_ack stays 0.
- Simultaneous requests, MAX_DSTREAK=4: i_req and d_req both held high, with d_req re-asserted after every ack → data granted 4 times, then fetch once, then dstreak=0 and data wins again. Check the exact ack sequence D,D,D,D,I,D.
- Fetch alone: i_addr=0x0 after d-store 0x8C010004 to 0x0 → i_rdata=0x8C010004 with i_ack; mem_we=0 throughout.
- Errors:
  - d_addr=0x12 store → d_err=1, d_rdata=0, and a later load of 0x10 still returns its old value.
  - i_addr=0x100 (word 64) → i_err=1, i_rdata=0.
- Reset mid-access: drop reset_n during ACCESS of a store to 0x20 with wdata 0x12345678 → all outputs 0 asynchronously and no ack. A subsequent load of 0x20 returns the pre-store value.
- Handshake invariants (assertion, run through all of the above): i_ack & d_ack never both high, each ack is exactly 1 cycle wide, and mem_we=1 only in ACCESS with owner=D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Contents: FSM state enum, access owner enum, word shift, streak counter width.
// Imported by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } owner_e;

  // Byte address to word index shift.
  localparam int WORD_SHIFT = 2;

  // Width of the data streak counter; holds MAX_DSTREAK up to 15.
  localparam int DSTREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the arbiter.
// slave modport: arbiter view (requests and mem_rd in; acks, responses, mem drive out).
// master modport: requester/memory-environment view (mirror of slave).
interface mem_arbiter_if;
  // fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  // data port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  // memory port
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data, plus next streak count.
// Ports: i_req_i/d_req_i requests, dstreak_i current streak; grant_i_o/grant_d_o
// one-hot grant (both 0 when idle), dstreak_o streak value to load on a grant.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic                 i_req_i,
  input  logic                 d_req_i,
  input  logic [DSTREAK_W-1:0] dstreak_i,
  output logic                 grant_i_o,
  output logic                 grant_d_o,
  output logic [DSTREAK_W-1:0] dstreak_o
);

  localparam logic [DSTREAK_W-1:0] MAX_Q = DSTREAK_W'(MAX_DSTREAK);

  always_comb begin
    grant_i_o = 1'b0;
    grant_d_o = 1'b0;
    dstreak_o = dstreak_i;
    // Data wins by default; fetch is forced through once data has won
    // MAX_DSTREAK times in a row while fetch was waiting.
    if (d_req_i && (!i_req_i || (dstreak_i != MAX_Q))) begin
      grant_d_o = 1'b1;
      if (!i_req_i) begin
        dstreak_o = '0;
      end else if (dstreak_i != MAX_Q) begin
        dstreak_o = dstreak_i + DSTREAK_W'(1);
      end
    end else if (i_req_i) begin
      grant_i_o = 1'b1;
      dstreak_o = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory between fetch and load/store, 3 cycles per access.
// Ports: clk, reset_n (async active-low), bus (slave modport: fetch req/ack,
// data req/ack, mem we/a/wd/rd). Misaligned/out-of-range accesses flag err, never write.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WORDS   = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d;
  logic [DSTREAK_W-1:0]   dstreak_q, dstreak_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   grant_i, grant_d;
  logic [DSTREAK_W-1:0]   pick_dstreak;
  logic [31:0]            sel_addr;
  logic                   legal;
  logic                   in_access;
  logic                   is_store;

  mem_arb_pick #(.MAX_DSTREAK(MAX_DSTREAK)) u_pick (
    .i_req_i   (bus.i_req),
    .d_req_i   (bus.d_req),
    .dstreak_i (dstreak_q),
    .grant_i_o (grant_i),
    .grant_d_o (grant_d),
    .dstreak_o (pick_dstreak)
  );

  assign sel_addr  = (owner_q == OWN_D) ? bus.d_addr : bus.i_addr;
  assign legal     = (sel_addr[1:0] == 2'b00) &&
                     ((sel_addr >> WORD_SHIFT) < 32'(MEM_WORDS));
  assign in_access = (state_q == ACCESS);
  assign is_store  = (owner_q == OWN_D) && bus.d_we;

  // Memory drive is decoded from the state register, so an async reset
  // during ACCESS kills a pending write before the next edge.
  assign bus.mem_a  = in_access ? sel_addr : 32'd0;
  assign bus.mem_we = in_access && is_store && legal;
  assign bus.mem_wd = (in_access && (owner_q == OWN_D)) ? bus.d_wdata : 32'd0;

  // rdata_q/err_q are nonzero only in RESP, so owner gating is enough.
  assign bus.i_ack   = (state_q == RESP) && (owner_q == OWN_I);
  assign bus.d_ack   = (state_q == RESP) && (owner_q == OWN_D);
  assign bus.i_rdata = (owner_q == OWN_I) ? rdata_q : 32'd0;
  assign bus.d_rdata = (owner_q == OWN_D) ? rdata_q : 32'd0;
  assign bus.i_err   = (owner_q == OWN_I) && err_q;
  assign bus.d_err   = (owner_q == OWN_D) && err_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    dstreak_d = dstreak_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d   = OWN_D;
          dstreak_d = pick_dstreak;
          state_d   = ACCESS;
        end else if (grant_i) begin
          owner_d   = OWN_I;
          dstreak_d = pick_dstreak;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (legal && !is_store) ? bus.mem_rd : 32'd0;
        err_d   = !legal;
        state_d = RESP;
      end
      RESP: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        owner_d = NONE;
        state_d = IDLE;
      end
      default: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        owner_d = NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= NONE;
      dstreak_q <= '0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      dstreak_q <= dstreak_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule
